lcd_dither565: RTL and testbench

Output stage between `vga_syncgen` and the Tang-Nano LCD pins. It takes 8-bit-per-channel RGB with active-high sync and dot-enable, and applies 4x4 ordered (Bayer) dithering to reduce the colour to RGB565. An optional temporal phase rotates the dither pattern each frame. It drives the panel with active-low syncs, DE and 5/6/5 colour, all realigned through a fixed 2-stage pipeline.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/dither_chan.sv | 39 +++
 rtl/lcd_dither565.sv | 163 ++++++++++++++++
 tb/tb_lcd_dither565.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the RGB565 LCD output stage: Bayer matrix,
// channel widths and the add/saturate/truncate primitive.
package lcd_pkg;

  localparam int unsigned IN_W = 8;
  localparam int unsigned R_W  = 5;
  localparam int unsigned G_W  = 6;
  localparam int unsigned B_W  = 5;

  // 4x4 ordered-dither thresholds, indexed [row][column].
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Adds a small dither offset, clamps at full scale, then drops LSBs.
  // The result is right-aligned; callers keep only their output width.
  function automatic logic [IN_W-1:0] sat_trunc(
    input logic [IN_W-1:0] c,
    input logic [2:0]      add,
    input int unsigned     drop
  );
    logic [IN_W:0] s;
    s = {1'b0, c} + {{(IN_W-2){1'b0}}, add};
    if (s[IN_W]) begin
      return {IN_W{1'b1}} >> drop;
    end
    return s[IN_W-1:0] >> drop;
  endfunction

endpackage

// File: rtl/dither_chan.sv
// One colour channel of the output stage: dither add, saturation, truncation
// to OUT_W bits and the output register, blanked outside the active area.
module dither_chan
  import lcd_pkg::*;
#(
  parameter int unsigned OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_p1,
  input  logic [IN_W-1:0]  c_p1,
  input  logic [2:0]       add_p1,
  output logic [OUT_W-1:0] out_p2
);

  localparam int unsigned DROP = IN_W - OUT_W;

  logic [OUT_W-1:0] out_p2_d;
  logic [OUT_W-1:0] out_p2_q;

  always_comb begin
    out_p2_d = '0;
    if (de_p1) begin
      out_p2_d = OUT_W'(sat_trunc(c_p1, add_p1, DROP));
    end
  end

  // stage 2: channel output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p2_q <= '0;
    end else begin
      out_p2_q <= out_p2_d;
    end
  end

  assign out_p2 = out_p2_q;

endmodule

// File: rtl/lcd_dither565.sv
// RGB888 to RGB565 LCD output stage with 4x4 ordered dithering, optional
// per-frame pattern rotation and a fixed two-cycle sync/DE/colour pipeline.
module lcd_dither565
  import lcd_pkg::*;
#(
  parameter bit DITHER_ENA   = 1'b1,
  parameter bit TEMPORAL_ENA = 1'b1
) (
  input  logic            video_clk,
  input  logic            reset_n,
  input  logic            hsync,
  input  logic            vsync,
  input  logic            dotenable,
  input  logic [IN_W-1:0] rin,
  input  logic [IN_W-1:0] gin,
  input  logic [IN_W-1:0] bin,
  output logic            lcd_hsync_n,
  output logic            lcd_vsync_n,
  output logic            lcd_de,
  output logic [R_W-1:0]  lcd_r,
  output logic [G_W-1:0]  lcd_g,
  output logic [B_W-1:0]  lcd_b
);

  logic [1:0] xcnt_d,  xcnt_q;
  logic [1:0] ycnt_d,  ycnt_q;
  logic [1:0] frame_d, frame_q;
  logic       de_prev_d, de_prev_q;
  logic       vs_prev_d, vs_prev_q;
  logic       vs_rise, de_fall;
  logic [1:0] bx;
  logic [3:0] t_p0;

  logic            hs_p1_d, hs_p1_q;
  logic            vs_p1_d, vs_p1_q;
  logic            de_p1_d, de_p1_q;
  logic [IN_W-1:0] r_p1_d, r_p1_q;
  logic [IN_W-1:0] g_p1_d, g_p1_q;
  logic [IN_W-1:0] b_p1_d, b_p1_q;
  logic [2:0]      t_p1_d, t_p1_q;

  logic hs_n_p2_d, hs_n_p2_q;
  logic vs_n_p2_d, vs_n_p2_q;
  logic de_p2_d,   de_p2_q;

  // stage 0: position counters, edge detects and threshold lookup
  always_comb begin
    vs_rise   = vsync & ~vs_prev_q;
    de_fall   = ~dotenable & de_prev_q;
    de_prev_d = dotenable;
    vs_prev_d = vsync;
    xcnt_d    = dotenable ? xcnt_q + 2'd1 : 2'd0;
    ycnt_d    = ycnt_q;
    frame_d   = frame_q;
    // A frame start outranks an end-of-line on the same cycle.
    if (vs_rise) begin
      ycnt_d  = 2'd0;
      frame_d = frame_q + 2'd1;
    end else if (de_fall) begin
      ycnt_d  = ycnt_q + 2'd1;
    end
    bx   = xcnt_q + (TEMPORAL_ENA ? frame_q : 2'd0);
    t_p0 = DITHER_ENA ? BAYER[ycnt_q][bx] : 4'd0;
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      xcnt_q    <= 2'd0;
      ycnt_q    <= 2'd0;
      frame_q   <= 2'd0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      xcnt_q    <= xcnt_d;
      ycnt_q    <= ycnt_d;
      frame_q   <= frame_d;
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  // stage 1: register syncs, DE, colour and threshold (only t[3:1] is ever used)
  always_comb begin
    hs_p1_d = hsync;
    vs_p1_d = vsync;
    de_p1_d = dotenable;
    r_p1_d  = rin;
    g_p1_d  = gin;
    b_p1_d  = bin;
    t_p1_d  = t_p0[3:1];
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_p1_q <= 1'b0;
      vs_p1_q <= 1'b0;
      de_p1_q <= 1'b0;
    end else begin
      hs_p1_q <= hs_p1_d;
      vs_p1_q <= vs_p1_d;
      de_p1_q <= de_p1_d;
    end
  end

  // Colour payload is blanked downstream by DE, so it needs no reset.
  always_ff @(posedge video_clk) begin
    r_p1_q <= r_p1_d;
    g_p1_q <= g_p1_d;
    b_p1_q <= b_p1_d;
    t_p1_q <= t_p1_d;
  end

  // stage 2: inverted syncs, DE and per-channel dither
  always_comb begin
    hs_n_p2_d = ~hs_p1_q;
    vs_n_p2_d = ~vs_p1_q;
    de_p2_d   = de_p1_q;
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_n_p2_q <= 1'b1;
      vs_n_p2_q <= 1'b1;
      de_p2_q   <= 1'b0;
    end else begin
      hs_n_p2_q <= hs_n_p2_d;
      vs_n_p2_q <= vs_n_p2_d;
      de_p2_q   <= de_p2_d;
    end
  end

  dither_chan #(.OUT_W(R_W)) u_chan_r (
    .clk    (video_clk),
    .rst_n  (reset_n),
    .de_p1  (de_p1_q),
    .c_p1   (r_p1_q),
    .add_p1 (t_p1_q),
    .out_p2 (lcd_r)
  );

  dither_chan #(.OUT_W(G_W)) u_chan_g (
    .clk    (video_clk),
    .rst_n  (reset_n),
    .de_p1  (de_p1_q),
    .c_p1   (g_p1_q),
    .add_p1 ({1'b0, t_p1_q[2:1]}),
    .out_p2 (lcd_g)
  );

  dither_chan #(.OUT_W(B_W)) u_chan_b (
    .clk    (video_clk),
    .rst_n  (reset_n),
    .de_p1  (de_p1_q),
    .c_p1   (b_p1_q),
    .add_p1 (t_p1_q),
    .out_p2 (lcd_b)
  );

  assign lcd_hsync_n = hs_n_p2_q;
  assign lcd_vsync_n = vs_n_p2_q;
  assign lcd_de      = de_p2_q;

endmodule

// File: tb/tb_lcd_dither565.sv
// Bench for lcd_dither565: three instances (full, no temporal, no dither)
// share one stimulus stream and are checked against a behavioural model.
module tb_lcd_dither565;

  logic       video_clk = 1'b0;
  logic       reset_n;
  logic       hsync, vsync, dotenable;
  logic [7:0] rin, gin, bin;

  logic [2:0] hs_n, vs_n, de_o;
  logic [4:0] r_o [3];
  logic [5:0] g_o [3];
  logic [4:0] b_o [3];

  always #5 video_clk = ~video_clk;

  lcd_dither565 #(.DITHER_ENA(1'b1), .TEMPORAL_ENA(1'b1)) dut0 (
    .video_clk(video_clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .dotenable(dotenable), .rin(rin), .gin(gin), .bin(bin),
    .lcd_hsync_n(hs_n[0]), .lcd_vsync_n(vs_n[0]), .lcd_de(de_o[0]),
    .lcd_r(r_o[0]), .lcd_g(g_o[0]), .lcd_b(b_o[0]));

  lcd_dither565 #(.DITHER_ENA(1'b1), .TEMPORAL_ENA(1'b0)) dut1 (
    .video_clk(video_clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .dotenable(dotenable), .rin(rin), .gin(gin), .bin(bin),
    .lcd_hsync_n(hs_n[1]), .lcd_vsync_n(vs_n[1]), .lcd_de(de_o[1]),
    .lcd_r(r_o[1]), .lcd_g(g_o[1]), .lcd_b(b_o[1]));

  lcd_dither565 #(.DITHER_ENA(1'b0), .TEMPORAL_ENA(1'b1)) dut2 (
    .video_clk(video_clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .dotenable(dotenable), .rin(rin), .gin(gin), .bin(bin),
    .lcd_hsync_n(hs_n[2]), .lcd_vsync_n(vs_n[2]), .lcd_de(de_o[2]),
    .lcd_r(r_o[2]), .lcd_g(g_o[2]), .lcd_b(b_o[2]));

  typedef struct {
    logic [2:0][18:0] act;
    logic [2:0][18:0] exp;
    int               idx;
  } rec_t;

  localparam logic [18:0] IDLE = {1'b1, 1'b1, 1'b0, 16'd0};

  int BAY [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  int mx, my, mf, cnt;
  bit pv, pd;
  logic [2:0][18:0] expq [$];
  rec_t rec_q [$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [18:0] pk(input int k);
    return {hs_n[k], vs_n[k], de_o[k], r_o[k], g_o[k], b_o[k]};
  endfunction

  // Expected panel word for one input pixel, from the current model position.
  function automatic logic [18:0] model_px(input bit dith, input bit temp, input logic h,
                                            input logic v, input logic d,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    int t, rr, gg, bb;
    t  = dith ? BAY[my][(mx + (temp ? mf : 0)) % 4] : 0;
    rr = 0; gg = 0; bb = 0;
    if (d) begin
      rr = (int'(r) + t / 2) / 8; if (rr > 31) rr = 31;
      gg = (int'(g) + t / 4) / 4; if (gg > 63) gg = 63;
      bb = (int'(b) + t / 2) / 8; if (bb > 31) bb = 31;
    end
    return {~h, ~v, d, 5'(rr), 6'(gg), 5'(bb)};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mf = 0; pv = 0; pd = 0;
    expq.delete();
    rec_q.delete();
    expq.push_back({IDLE, IDLE, IDLE});
  endtask

  // Drive one pixel, advance the model, record the outputs seen one cycle later.
  task automatic cyc(input logic h, input logic v, input logic d,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [2:0][18:0] e;
    rec_t rc;
    bit vr, df;
    hsync = h; vsync = v; dotenable = d; rin = r; gin = g; bin = b;
    e[0] = model_px(1, 1, h, v, d, r, g, b);
    e[1] = model_px(1, 0, h, v, d, r, g, b);
    e[2] = model_px(0, 1, h, v, d, r, g, b);
    expq.push_back(e);
    vr = v && !pv;
    df = !d && pd;
    mx = d ? (mx + 1) % 4 : 0;
    if (vr) begin my = 0; mf = (mf + 1) % 4; end
    else if (df) my = (my + 1) % 4;
    pv = v; pd = d;
    cnt++;
    @(posedge video_clk);
    @(negedge video_clk);
    rc.act[0] = pk(0); rc.act[1] = pk(1); rc.act[2] = pk(2);
    rc.exp = expq.pop_front();
    rc.idx = cnt;
    rec_q.push_back(rc);
  endtask

  task automatic line(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, r, g, b);
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(1, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hsync = 1; vsync = 1; dotenable = 1; rin = 8'hFF; gin = 8'hFF; bin = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge video_clk);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (pk(k) !== IDLE) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc%0d: got %h expected %h", k, c, pk(k), IDLE);
        end
      end
    end
    hsync = 0; vsync = 0; dotenable = 0; rin = 0; gin = 0; bin = 0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_latency();
    rec_t rc;
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 1, 8'hF8, 8'hFC, 8'hF8);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL latency dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    rec_t rc;
    for (int y = 0; y < 4; y++) line(4, 8'hFF, 8'hFF, 8'hFF);
    for (int y = 0; y < 4; y++) line(4, 8'h00, 8'h00, 8'h00);
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL saturation dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  task automatic test_dither_pattern();
    rec_t rc;
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int y = 0; y < 4; y++) line(4, 8'h04, 8'h02, 8'h04);
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL dither dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  task automatic test_temporal();
    rec_t rc;
    for (int f = 0; f < 5; f++) begin
      cyc(0, 1, 0, 8'h00, 8'h00, 8'h00);
      cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
      line(4, 8'h04, 8'h04, 8'h04);
      line(4, 8'h04, 8'h04, 8'h04);
    end
    // vsync rise on the same cycle that DE falls: next line restarts at row 0
    cyc(0, 0, 1, 8'h04, 8'h04, 8'h04);
    cyc(0, 0, 1, 8'h04, 8'h04, 8'h04);
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    line(4, 8'h04, 8'h04, 8'h04);
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL temporal dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  task automatic test_dither_off();
    rec_t rc;
    for (int y = 0; y < 4; y++) line(4, 8'h07, 8'hFE, 8'h07);
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL dither_off dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    rec_t rc;
    cyc(0, 0, 1, 8'h55, 8'h66, 8'h77);
    cyc(0, 0, 1, 8'h88, 8'h99, 8'hAA);
    cyc(1, 1, 1, 8'hFF, 8'hFF, 8'hFF);
    @(posedge video_clk);
    #3 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (pk(k) !== IDLE) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d: got %h expected %h", k, pk(k), IDLE);
      end
    end
    @(negedge video_clk);
    hsync = 0; vsync = 0; dotenable = 0; rin = 0; gin = 0; bin = 0;
    reset_n = 1'b1;
    model_reset();
    line(4, 8'h04, 8'h04, 8'h04);
    line(4, 8'h04, 8'h04, 8'h04);
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL mid_reset dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    rec_t rc;
    for (int l = 0; l < 60; l++) begin
      if ($urandom_range(0, 7) == 0) begin
        cyc(0, 1, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom));
        cyc(0, 1, 0, 8'h00, 8'h00, 8'h00);
      end
      for (int i = 0; i < int'($urandom_range(1, 9)); i++)
        cyc(0, 0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      cyc(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    while (rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rc.act[k] !== rc.exp[k]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got %h expected %h", k, rc.idx, rc.act[k], rc.exp[k]);
        end
      end
    end
  endtask

  initial begin
    cnt = 0;
    reset_n = 1'b0;
    hsync = 0; vsync = 0; dotenable = 0; rin = 0; gin = 0; bin = 0;
    @(negedge video_clk);
    test_reset();
    test_latency();
    test_saturation();
    test_dither_pattern();
    test_temporal();
    test_dither_off();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
